dm_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 4 KB data memory between the CPU load/store port (port 0) and a loader/debug port (port 1). It sits between the core's ALU-result/busB path and the data memory. It grants at most one access per cycle and registers read data for the winner. It raises a stall toward the PC-write control when the CPU loses arbitration.

---
 rtl/dm_arb_pkg.sv | 9 +
 rtl/dm_arb_pick.sv | 26 ++
 rtl/dm_port_arbiter.sv | 103 ++++++++++
 tb/tb_dm_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory port arbiter: port IDs and default geometry.
package dm_arb_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  localparam int DEF_AW      = 10;
  localparam int DEF_DW      = 32;
  localparam int DEF_MAXLOCK = 8;
endpackage

// File: rtl/dm_arb_pick.sv
// Combinational arbitration decision: one-hot grant from the two requests,
// the previous winner and the lock qualifier.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  input  logic       lock_active,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      // Contention: a live lock keeps port 1, otherwise alternate away from the last winner.
      if (lock_active || (last_gnt == PORT_CPU)) gnt[PORT_LD] = 1'b1;
      else                                       gnt[PORT_CPU] = 1'b1;
    end else if (req0) begin
      gnt[PORT_CPU] = 1'b1;
    end else if (req1) begin
      gnt[PORT_LD] = 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and a
// loader/debug port; one access per cycle, registered read data for the winner.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MAXLOCK = DEF_MAXLOCK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_lock,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall
);

  localparam int CW = $clog2(MAXLOCK + 1);

  logic          last_gnt_reg;
  logic [CW-1:0] lock_cnt_reg, lock_cnt_next;
  logic          rsel_reg, rvalid_reg;
  logic [DW-1:0] rdata_reg;

  logic [1:0] pick_gnt, gnt;
  logic       lock_active, any_gnt, sel, sel_we, rd_gnt;

  // Byte-offset and above-4KB address bits are deliberately dropped (address wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:AW+2], m0_addr[1:0], m1_addr[31:AW+2], m1_addr[1:0]};

  assign lock_active = (last_gnt_reg == PORT_LD) && m1_lock && (lock_cnt_reg < CW'(MAXLOCK));

  dm_arb_pick u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_gnt    (last_gnt_reg),
    .lock_active (lock_active),
    .gnt         (pick_gnt)
  );

  // Reset forces all grant-derived strobes low, independent of the clock.
  assign gnt     = pick_gnt & {2{rst}};
  assign any_gnt = |gnt;
  assign sel     = gnt[PORT_LD];
  assign sel_we  = sel ? m1_we : m0_we;
  assign rd_gnt  = any_gnt & ~sel_we;

  assign m0_gnt    = gnt[PORT_CPU];
  assign m1_gnt    = gnt[PORT_LD];
  assign mem_addr  = sel ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
  assign mem_wdata = sel ? m1_wdata : m0_wdata;
  assign mem_we    = any_gnt & sel_we;
  assign cpu_stall = rst & m0_req & ~gnt[PORT_CPU];

  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    if (!gnt[PORT_LD])
      lock_cnt_next = '0;
    else if (m0_req && (lock_cnt_reg < CW'(MAXLOCK)))
      lock_cnt_next = lock_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_reg <= PORT_LD;
      lock_cnt_reg <= '0;
      rsel_reg     <= PORT_CPU;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (any_gnt) last_gnt_reg <= sel;
      lock_cnt_reg <= lock_cnt_next;
      rvalid_reg   <= rd_gnt;
      if (rd_gnt) begin
        rsel_reg  <= sel;
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign m0_rvalid = rvalid_reg & (rsel_reg == PORT_CPU);
  assign m1_rvalid = rvalid_reg & (rsel_reg == PORT_LD);
  assign m0_rdata  = rdata_reg;
  assign m1_rdata  = rdata_reg;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural data memory and a
// response scoreboard fed from a reference memory image.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        cpu_stall;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } resp_t;
  resp_t rq[$];

  logic [31:0] ref_mem [0:1023];

  // Memory: synchronous write, combinational read, plus a bench preload port.
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (pre_we)      mem[pre_a]    <= pre_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_lock   (m1_lock),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare this cycle's read responses against the scoreboard.
  task automatic check_resp(input string tag);
    resp_t e;
    if (rq.size() > 0) begin
      e = rq.pop_front();
      chk({tag, "_rv0"}, {31'd0, m0_rvalid}, {31'd0, (e.port == 1'b0)});
      chk({tag, "_rv1"}, {31'd0, m1_rvalid}, {31'd0, (e.port == 1'b1)});
      chk({tag, "_rdata"}, e.port ? m1_rdata : m0_rdata, e.data);
      $display("resp %s port=%0d rdata=%h exp=%h", tag, e.port, e.port ? m1_rdata : m0_rdata, e.data);
    end else begin
      chk({tag, "_rv0_idle"}, {31'd0, m0_rvalid}, 32'd0);
      chk({tag, "_rv1_idle"}, {31'd0, m1_rvalid}, 32'd0);
    end
  endtask

  // One arbitration cycle at posedge+1: check responses, drive, check grant path, score.
  task automatic cyc(input logic q0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic q1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic lk, input logic [1:0] eg, input string tag);
    logic [9:0] ea;
    logic       ewe;
    check_resp(tag);
    m0_req = q0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    m1_lock = lk;
    #1;
    ea  = eg[1] ? a1[11:2] : a0[11:2];
    ewe = (eg[0] & we0) | (eg[1] & we1);
    chk({tag, "_g0"}, {31'd0, m0_gnt}, {31'd0, eg[0]});
    chk({tag, "_g1"}, {31'd0, m1_gnt}, {31'd0, eg[1]});
    chk({tag, "_stall"}, {31'd0, cpu_stall}, {31'd0, q0 & ~eg[0]});
    chk({tag, "_maddr"}, {22'd0, mem_addr}, {22'd0, ea});
    chk({tag, "_mwe"}, {31'd0, mem_we}, {31'd0, ewe});
    if (ewe) chk({tag, "_mwdata"}, mem_wdata, eg[1] ? d1 : d0);
    $display("cyc %s req=%b%b gnt=%b%b stall=%b mem_addr=%0d we=%b", tag, q1, q0, m1_gnt, m0_gnt,
             cpu_stall, mem_addr, mem_we);
    if (eg[0] && !we0) rq.push_back('{port: 1'b0, data: ref_mem[a0[11:2]]});
    if (eg[1] && !we1) rq.push_back('{port: 1'b1, data: ref_mem[a1[11:2]]});
    if (eg[0] && we0) ref_mem[a0[11:2]] = d0;
    if (eg[1] && we1) ref_mem[a1[11:2]] = d1;
    tick();
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, tag);
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    tick();

    // Preload words 0..31 while held in reset.
    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1;
      pre_a  = 10'(i);
      pre_d  = (i == 4) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i));
      ref_mem[i] = pre_d;
      tick();
    end
    pre_we = 1'b0;

    // Reset state with requests present.
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    #1;
    chk("rst_g0", {31'd0, m0_gnt}, 32'd0);
    chk("rst_g1", {31'd0, m1_gnt}, 32'd0);
    chk("rst_mwe", {31'd0, mem_we}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_rd0", m0_rdata, 32'd0);
    chk("rst_rd1", m1_rdata, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Lone m0 read of word 4.
    cyc(1, 0, 32'h0000_0010, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "t1_rd");
    chk("t1_const", (rq.size() > 0) ? rq[0].data : 32'h0, 32'h1234_5678);
    idle("t1_resp");

    // Both read every cycle, no lock: round robin (m0 won last, so m1 first).
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 32'(4 * i), 32'h0, 1, 0, 32'(4 * (i + 8)), 32'h0, 0,
          (i % 2 == 0) ? 2'b10 : 2'b01, $sformatf("rr%0d", i));
    idle("rr_drain");

    // Lock burst: m1 writes with lock while m0 reads the same word continuously.
    cyc(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "lk_pre");
    for (int i = 0; i < 18; i++)
      cyc(1, 0, 32'h40, 32'h0, 1, 1, 32'h40, 32'hB000_0000 + 32'(i), 1,
          (i == 8 || i == 17) ? 2'b01 : 2'b10, $sformatf("lk%0d", i));
    idle("lk_drain");

    // Wrapped write then reads with and without byte-offset bits.
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 2'b10, "wr_wrap");
    cyc(1, 0, 32'h0000_0004, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "rd_w1");
    cyc(1, 0, 32'h0000_0007, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "rd_w1_off");
    chk("wrap_const", (rq.size() > 0) ? rq[0].data : 32'h0, 32'hDEAD_BEEF);
    idle("wrap_drain");

    // Read then write the same word back to back: read returns old data.
    cyc(1, 0, 32'h1C, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "raw_rd");
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h1C, 32'h5555_AAAA, 0, 2'b10, "raw_wr");
    cyc(1, 0, 32'h1C, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "raw_rd2");
    idle("raw_drain");

    // Reset asserted mid-cycle with an rvalid pending and a write being granted.
    cyc(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01, "mr_rd");
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h7777_7777;
    #1;
    chk("mr_rv_before", {31'd0, m0_rvalid}, 32'd1);
    chk("mr_mwe_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_rv_after", {31'd0, m0_rvalid}, 32'd0);
    chk("mr_g0_after", {31'd0, m0_gnt}, 32'd0);
    chk("mr_mwe_after", {31'd0, mem_we}, 32'd0);
    chk("mr_stall_after", {31'd0, cpu_stall}, 32'd0);
    $display("midreset rvalid=%b gnt=%b mem_we=%b", m0_rvalid, m0_gnt, mem_we);
    rq.delete();
    m0_req = 1'b0; m0_we = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    // First tie after reset goes to m0; the aborted write left word 8 untouched.
    cyc(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, 0, 2'b01, "mr_tie");
    chk("mr_nowrite_const", (rq.size() > 0) ? rq[0].data : 32'h0, 32'hC0DE_0008);
    idle("mr_resp");
    idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
